minterm_scan_checker: RTL and testbench
=======================================

Name: minterm_scan_checker

Overview:
- Sequential, parametrised successor to our exhaustive truth-table checks: compares two N-variable Boolean functions, each given as a 2^N-bit truth table, by scanning every minterm one per clock.
- Streams each mismatching minterm index over a valid/ready channel.
- Reports equality, the mismatch count and the first mismatching minterm.
- Sits between stimulus/ROM logic and a console/logging sink in the gate-level exercise benches.

Parameters:
- N_VARS, 4, number of input variables; legal range 1..8.
- DEPTH, 1<<N_VARS, number of minterms; derived, never overridden.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset; sampled on the rising edge of clk.
- start  input  1  one-cycle request to begin a scan.
- func_a  input  DEPTH  truth table A; bit m is the output for minterm m, variables MSB-first ({x,y,w,z}=m).
- func_b  input  DEPTH  truth table B, same encoding.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse when the scan completes.
- equal  output  1  1 when the last completed scan found zero mismatches.
- mismatch_count  output  N_VARS+1  mismatches found in the last or current scan.
- has_mismatch  output  1  first_mismatch is valid.
- first_mismatch  output  N_VARS  lowest mismatching minterm index.
- mm_valid  output  1  mismatch stream valid.
- mm_index  output  N_VARS  mismatching minterm index.
- mm_ready  input  1  sink accepts the stream word.

Behaviour:
- Reset: all outputs 0, state IDLE, index 0. A reset mid-scan aborts the scan immediately and no done pulse is produced.
- FSM states:
  - IDLE:
    - start=1 snapshots func_a and func_b into internal registers, clears the count, has_mismatch and first_mismatch, sets index=0, and moves to SCAN.
    - busy=1 from the next cycle.
    - Later changes on func_a and func_b do not affect the scan.
  - SCAN: evaluates bit index of a_q^b_q.
    - Match: if index==DEPTH-1, go to DONE; otherwise index+1 and stay in SCAN.
    - Mismatch:
      - Register mm_valid=1 and mm_index=index.
      - Increment the count.
      - If has_mismatch==0, set first_mismatch=index and has_mismatch=1.
      - Go to EMIT.
  - EMIT: hold mm_valid and mm_index stable until mm_valid&&mm_ready.
    - On the handshake: mm_valid<=0. If index==DEPTH-1, go to DONE; otherwise index+1 and go to SCAN.
  - DONE: done=1 for exactly one cycle; busy<=0; equal<=(count==0); go to IDLE.
- Timing: with zero mismatches and start accepted at edge 0, SCAN covers DEPTH cycles and done is high in cycle DEPTH+1.
- Cost per mismatch: at least one extra EMIT cycle, plus backpressure cycles.
- start while busy is ignored; it is not queued.
- Result outputs hold until the next accepted start.
- No index wrap: the scan stops at DEPTH-1.
- mismatch_count reaches DEPTH at most, hence N_VARS+1 bits.
- Stream order is strictly ascending, with no drops or duplicates under any mm_ready pattern.

Optional Feature:
- Macro: MINTERM_SCAN_STOP_ON_FIRST_EN.
- Defined:
  - After the handshake of the first mismatch, go directly to DONE.
  - Result: mismatch_count=1, first_mismatch valid, equal=0, and exactly one stream word.
- Undefined: full scan as specified above.
- The ports are identical in both builds.

Decomposition:
- Package minterm_scan_pkg holds:
  - the state enum (IDLE, SCAN, EMIT, DONE), with 2-bit encoding;
  - the width helper function cnt_width(n)=n+1.
- One natural sub-module: minterm_index_counter, a loadable/clearable N_VARS-bit up-counter with an increment enable and an at_last flag. It is instantiated once for the index.

Test Plan:
- Equality: N_VARS=4, func_a=func_b=16'h7F00, mm_ready=1, start at cycle 0 -> done pulse at cycle 17, equal=1, count=0, has_mismatch=0, mm_valid never high.
- Single mismatch: func_a=16'h7F00, func_b=16'hFF00 -> one stream word mm_index=15, count=1, first_mismatch=15, equal=0.
- Backpressure: func_a=16'h0000, func_b=16'h8001, mm_ready low for 3 cycles on each word:
  - stream is exactly 0 then 15, each held stable while stalled;
  - count=2, first_mismatch=0.
- Full mismatch: func_a=16'h0000, func_b=16'hFFFF, mm_ready=1 -> 16 words 0..15 in order, count=16 (5'b10000); inputs changed mid-scan have no effect.
- Reset and restart:
  - assert reset at scan index 7 -> next cycle all outputs 0 and no done pulse;
  - a new start then scans correctly;
  - start pulses while busy are ignored.
- Small instance: N_VARS=2, func_a=4'b0110, func_b=4'b0111 -> mm_index=0, done at cycle 6 (4 SCAN + 1 EMIT); with MINTERM_SCAN_STOP_ON_FIRST_EN, func_b=4'b1001 -> single word 0, count=1.

Source files
------------

// File: rtl/minterm_scan_pkg.sv
// Shared types and helpers for the minterm scan checker.
package minterm_scan_pkg;

   // Scan controller states, 2-bit encoding.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      EMIT = 2'd2,
      DONE = 2'd3
   } state_t;

   // Mismatch counter width: one extra bit so a full-mismatch count of 2^n fits.
   function automatic int cnt_width(input int n);
      return n + 1;
   endfunction

endpackage

// File: rtl/minterm_index_counter.sv
// Loadable/clearable up-counter used as the minterm index, with a last-value flag.
module minterm_index_counter #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clr,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         inc,
   output logic [W-1:0] value,
   output logic         at_last
);

   // Clear wins over load, load wins over increment.
   always_ff @(posedge clk) begin
      if (reset || clr)
         value <= '0;
      else if (load)
         value <= load_val;
      else if (inc)
         value <= value + 1'b1;
   end

   assign at_last = (value == {W{1'b1}});

endmodule

// File: rtl/minterm_scan_checker.sv
// Compares two N_VARS-input truth tables one minterm per clock, streams every
// mismatching minterm index over valid/ready and reports count/first/equal.
// Build option: define MINTERM_SCAN_STOP_ON_FIRST_EN to end the scan after the
// first mismatch word has been accepted.
module minterm_scan_checker
   import minterm_scan_pkg::*;
#(
   parameter  int N_VARS = 4,
   localparam int DEPTH  = 1 << N_VARS
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          start,
   input  logic [DEPTH-1:0]              func_a,
   input  logic [DEPTH-1:0]              func_b,
   output logic                          busy,
   output logic                          done,
   output logic                          equal,
   output logic [cnt_width(N_VARS)-1:0]  mismatch_count,
   output logic                          has_mismatch,
   output logic [N_VARS-1:0]             first_mismatch,
   output logic                          mm_valid,
   output logic [N_VARS-1:0]             mm_index,
   input  logic                          mm_ready
);

   state_t            state;
   logic [DEPTH-1:0]  a_q;
   logic [DEPTH-1:0]  b_q;
   logic [N_VARS-1:0] idx;
   logic              at_last;
   logic              diff;
   logic              idx_clr;
   logic              idx_inc;

   // Tables are snapshotted at start, so input changes mid-scan are invisible.
   assign diff = a_q[idx] ^ b_q[idx];

   minterm_index_counter #(.W(N_VARS)) u_idx (
      .clk      (clk),
      .reset    (reset),
      .clr      (idx_clr),
      .load     (1'b0),
      .load_val ('0),
      .inc      (idx_inc),
      .value    (idx),
      .at_last  (at_last)
   );

   // Index control: clear on an accepted start, advance after a match or a
   // consumed stream word, never past the last minterm.
   always_comb begin
      idx_clr = 1'b0;
      idx_inc = 1'b0;
      case (state)
         IDLE: idx_clr = start;
         SCAN: idx_inc = !diff && !at_last;
`ifdef MINTERM_SCAN_STOP_ON_FIRST_EN
         EMIT: idx_inc = 1'b0;
`else
         EMIT: idx_inc = mm_ready && !at_last;
`endif
         default: idx_inc = 1'b0;
      endcase
   end

   // Scan controller with registered outputs; done is raised on entry to DONE.
   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= IDLE;
         a_q            <= '0;
         b_q            <= '0;
         busy           <= 1'b0;
         done           <= 1'b0;
         equal          <= 1'b0;
         mismatch_count <= '0;
         has_mismatch   <= 1'b0;
         first_mismatch <= '0;
         mm_valid       <= 1'b0;
         mm_index       <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  a_q            <= func_a;
                  b_q            <= func_b;
                  mismatch_count <= '0;
                  has_mismatch   <= 1'b0;
                  first_mismatch <= '0;
                  busy           <= 1'b1;
                  state          <= SCAN;
               end
            end
            SCAN: begin
               if (diff) begin
                  mm_valid       <= 1'b1;
                  mm_index       <= idx;
                  mismatch_count <= mismatch_count + 1'b1;
                  if (!has_mismatch) begin
                     first_mismatch <= idx;
                     has_mismatch   <= 1'b1;
                  end
                  state <= EMIT;
               end else if (at_last) begin
                  done  <= 1'b1;
                  state <= DONE;
               end
            end
            EMIT: begin
               if (mm_ready) begin
                  mm_valid <= 1'b0;
`ifdef MINTERM_SCAN_STOP_ON_FIRST_EN
                  done  <= 1'b1;
                  state <= DONE;
`else
                  if (at_last) begin
                     done  <= 1'b1;
                     state <= DONE;
                  end else begin
                     state <= SCAN;
                  end
`endif
               end
            end
            DONE: begin
               busy  <= 1'b0;
               equal <= (mismatch_count == '0);
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_minterm_scan_checker.sv
// Scoreboard bench for minterm_scan_checker: stimulus pushes expected stream
// words and results; one monitor process pops and compares at negedge.
// Expectations follow MINTERM_SCAN_STOP_ON_FIRST_EN when it is defined.
module tb_minterm_scan_checker;

   typedef struct {
      bit eq;
      int cnt;
      bit has;
      int first;
      int lat;
   } res_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   // 4-variable instance
   logic        start4 = 1'b0, rdy4 = 1'b1;
   logic [15:0] fa4 = '0, fb4 = '0;
   logic        busy4, done4, eq4, has4, mmv4;
   logic [4:0]  cnt4;
   logic [3:0]  first4, mmi4;

   // 2-variable instance
   logic        start2 = 1'b0, rdy2 = 1'b1;
   logic [3:0]  fa2 = '0, fb2 = '0;
   logic        busy2, done2, eq2, has2, mmv2;
   logic [2:0]  cnt2;
   logic [1:0]  first2, mmi2;

   minterm_scan_checker #(.N_VARS(4)) dut4 (
      .clk(clk), .reset(reset), .start(start4), .func_a(fa4), .func_b(fb4),
      .busy(busy4), .done(done4), .equal(eq4), .mismatch_count(cnt4),
      .has_mismatch(has4), .first_mismatch(first4), .mm_valid(mmv4),
      .mm_index(mmi4), .mm_ready(rdy4));

   minterm_scan_checker #(.N_VARS(2)) dut2 (
      .clk(clk), .reset(reset), .start(start2), .func_a(fa2), .func_b(fb2),
      .busy(busy2), .done(done2), .equal(eq2), .mismatch_count(cnt2),
      .has_mismatch(has2), .first_mismatch(first2), .mm_valid(mmv2),
      .mm_index(mmi2), .mm_ready(rdy2));

   int   q4_mm[$], q2_mm[$];
   res_t q4_res[$], q2_res[$];
   int   checks = 0, errors = 0;
   int   cyc = 0, st4 = 0, st2 = 0;
   int   tmo = 0, tmo_seen = 0;
   bit   fin = 1'b0, fin_done = 1'b0;
   bit   rst_prev = 1'b0;
   bit   pend4 = 1'b0, pend2 = 1'b0, stall4 = 1'b0, stall2 = 1'b0;
   int   sidx4 = 0, sidx2 = 0;
   res_t cur4, cur2;

   // Edge counter and capture of the edge at which each start is accepted.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (start4 && !busy4) st4 <= cyc + 1;
      if (start2 && !busy2) st2 <= cyc + 1;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic unexp(input string nm, input int v);
      checks++;
      errors++;
      $display("FAIL %s: got %0d, expected nothing", nm, v);
   endtask

   // Monitor: reset state, stream words, stall stability, done latency, results.
   always @(negedge clk) begin
      if (rst_prev) begin
         chk("rst4_busy", busy4, 0);   chk("rst4_done", done4, 0);
         chk("rst4_equal", eq4, 0);    chk("rst4_count", cnt4, 0);
         chk("rst4_has", has4, 0);     chk("rst4_first", first4, 0);
         chk("rst4_mmv", mmv4, 0);     chk("rst4_mmi", mmi4, 0);
         chk("rst2_busy", busy2, 0);   chk("rst2_count", cnt2, 0);
         chk("rst2_mmv", mmv2, 0);     chk("rst2_done", done2, 0);
         pend4 = 0; pend2 = 0; stall4 = 0; stall2 = 0;
      end else begin
         if (pend4) begin
            chk("res4_equal", eq4, cur4.eq);   chk("res4_count", cnt4, cur4.cnt);
            chk("res4_has", has4, cur4.has);   chk("res4_first", first4, cur4.first);
            chk("res4_busy", busy4, 0);
            pend4 = 0;
         end
         if (stall4) begin
            chk("stall4_valid", mmv4, 1);
            chk("stall4_index", mmi4, sidx4);
         end
         if (mmv4 && rdy4) begin
            if (q4_mm.size() == 0) unexp("mm4_word", mmi4);
            else chk("mm4_word", mmi4, q4_mm.pop_front());
         end
         if (done4) begin
            if (q4_res.size() == 0) unexp("done4_pulse", cyc - st4);
            else begin
               cur4 = q4_res.pop_front();
               if (cur4.lat >= 0) chk("done4_latency", cyc - st4, cur4.lat);
               pend4 = 1;
            end
         end
         stall4 = mmv4 && !rdy4;
         sidx4  = mmi4;

         if (pend2) begin
            chk("res2_equal", eq2, cur2.eq);   chk("res2_count", cnt2, cur2.cnt);
            chk("res2_has", has2, cur2.has);   chk("res2_first", first2, cur2.first);
            pend2 = 0;
         end
         if (stall2) begin
            chk("stall2_valid", mmv2, 1);
            chk("stall2_index", mmi2, sidx2);
         end
         if (mmv2 && rdy2) begin
            if (q2_mm.size() == 0) unexp("mm2_word", mmi2);
            else chk("mm2_word", mmi2, q2_mm.pop_front());
         end
         if (done2) begin
            if (q2_res.size() == 0) unexp("done2_pulse", cyc - st2);
            else begin
               cur2 = q2_res.pop_front();
               if (cur2.lat >= 0) chk("done2_latency", cyc - st2, cur2.lat);
               pend2 = 1;
            end
         end
         stall2 = mmv2 && !rdy2;
         sidx2  = mmi2;
      end
      if (tmo != tmo_seen) begin
         chk("wait_timeout", tmo, tmo_seen);
         tmo_seen = tmo;
      end
      if (fin && !fin_done) begin
         chk("q4_mm_left", q4_mm.size(), 0);   chk("q4_res_left", q4_res.size(), 0);
         chk("q2_mm_left", q2_mm.size(), 0);   chk("q2_res_left", q2_res.size(), 0);
         fin_done = 1;
      end
      rst_prev = reset;
   end

   task automatic exp4(input bit eq, input int cnt, input bit has, input int first, input int lat);
      res_t r;
      r = '{eq, cnt, has, first, lat};
      q4_res.push_back(r);
   endtask

   task automatic exp2(input bit eq, input int cnt, input bit has, input int first, input int lat);
      res_t r;
      r = '{eq, cnt, has, first, lat};
      q2_res.push_back(r);
   endtask

   task automatic scan4(input logic [15:0] a, input logic [15:0] b);
      @(posedge clk); #1;
      fa4 = a; fb4 = b; start4 = 1'b1;
      @(posedge clk); #1;
      start4 = 1'b0;
   endtask

   task automatic scan2(input logic [3:0] a, input logic [3:0] b);
      @(posedge clk); #1;
      fa2 = a; fb2 = b; start2 = 1'b1;
      @(posedge clk); #1;
      start2 = 1'b0;
   endtask

   task automatic wait4();
      int n = 0;
      while ((q4_mm.size() != 0 || q4_res.size() != 0 || pend4) && n < 400) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 400) tmo++;
   endtask

   task automatic wait2();
      int n = 0;
      while ((q2_mm.size() != 0 || q2_res.size() != 0 || pend2) && n < 400) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 400) tmo++;
   endtask

   task automatic wait_valid4();
      int n = 0;
      while (!mmv4 && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      if (!mmv4) tmo++;
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      // Equality: no words, done 16 edges after start
      exp4(1, 0, 0, 0, 16);
      scan4(16'h7F00, 16'h7F00);
      wait4();

      // Single mismatch at minterm 15
      q4_mm.push_back(15);
      exp4(0, 1, 1, 15, 17);
      scan4(16'h7F00, 16'hFF00);
      wait4();

      // Backpressure: each word stalled 3 cycles
      q4_mm.push_back(0);
`ifdef MINTERM_SCAN_STOP_ON_FIRST_EN
      exp4(0, 1, 1, 0, -1);
`else
      q4_mm.push_back(15);
      exp4(0, 2, 1, 0, -1);
`endif
      rdy4 = 1'b0;
      scan4(16'h0000, 16'h8001);
`ifdef MINTERM_SCAN_STOP_ON_FIRST_EN
      for (int w = 0; w < 1; w++) begin
`else
      for (int w = 0; w < 2; w++) begin
`endif
         wait_valid4();
         repeat (3) @(posedge clk);
         #1 rdy4 = 1'b1;
         @(posedge clk);
         #1 rdy4 = 1'b0;
      end
      rdy4 = 1'b1;
      wait4();

      // Full mismatch; tables change and start pulses mid-scan
`ifdef MINTERM_SCAN_STOP_ON_FIRST_EN
      q4_mm.push_back(0);
      exp4(0, 1, 1, 0, -1);
`else
      for (int i = 0; i < 16; i++) q4_mm.push_back(i);
      exp4(0, 16, 1, 0, -1);
`endif
      scan4(16'h0000, 16'hFFFF);
      @(posedge clk); #1;
      fa4 = 16'h7F00; fb4 = 16'h7F00; start4 = 1'b1;
      @(posedge clk); #1;
      start4 = 1'b0;
      wait4();

      // Reset while scanning index 7: outputs cleared, no done pulse
      q4_mm.push_back(0);
`ifdef MINTERM_SCAN_STOP_ON_FIRST_EN
      exp4(0, 1, 1, 0, -1);
`else
      q4_mm.push_back(1);
`endif
      scan4(16'h0000, 16'h0003);
      repeat (9) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;

      // Restart after reset, with an ignored start while busy
`ifdef MINTERM_SCAN_STOP_ON_FIRST_EN
      q4_mm.push_back(4);
      exp4(0, 1, 1, 4, -1);
`else
      for (int i = 4; i < 8; i++) q4_mm.push_back(i);
      exp4(0, 4, 1, 4, -1);
`endif
      scan4(16'h0000, 16'h00F0);
      @(posedge clk); #1;
      fa4 = 16'hFFFF; start4 = 1'b1;
      @(posedge clk); #1;
      start4 = 1'b0;
      wait4();

      // Small instance: mismatch at minterm 0
      q2_mm.push_back(0);
`ifdef MINTERM_SCAN_STOP_ON_FIRST_EN
      exp2(0, 1, 1, 0, 2);
`else
      exp2(0, 1, 1, 0, 5);
`endif
      scan2(4'b0110, 4'b0111);
      wait2();

      // Small instance: every minterm differs
`ifdef MINTERM_SCAN_STOP_ON_FIRST_EN
      q2_mm.push_back(0);
      exp2(0, 1, 1, 0, 2);
`else
      for (int i = 0; i < 4; i++) q2_mm.push_back(i);
      exp2(0, 4, 1, 0, 8);
`endif
      scan2(4'b0110, 4'b1001);
      wait2();

      // Small instance: equal tables
      exp2(1, 0, 0, 0, 4);
      scan2(4'b1010, 4'b1010);
      wait2();

      fin = 1'b1;
      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
